// File: rtl/axil_buffer_pkg.sv
// axil_buffer_pkg: shared helpers for the AXI4-lite buffer.
//   ptr_width()    - FIFO pointer width for a given depth (one extra wrap bit)
//   ax_payload_w() - AW/AR payload width {addr, prot}
//   w_payload_w()  - W payload width {data, strb}
//   r_payload_w()  - R payload width {data, resp}
//   B_PAYLOAD_W    - B payload width {resp}
package axil_buffer_pkg;

  localparam int PROT_W      = 3;
  localparam int RESP_W      = 2;
  localparam int B_PAYLOAD_W = RESP_W;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ax_payload_w(input int addr_w);
    return addr_w + PROT_W;
  endfunction

  function automatic int w_payload_w(input int data_w, input int strb_w);
    return data_w + strb_w;
  endfunction

  function automatic int r_payload_w(input int data_w);
    return data_w + RESP_W;
  endfunction

endpackage

// File: rtl/axil_buffer_fifo.sv
// axil_buffer_fifo: single-clock FIFO with registered ready, valid and data.
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    - push handshake (in_ready = !full, registered)
//   in_data [WIDTH]      - push payload
//   out_valid/out_ready  - pop handshake (out_valid = !empty, registered)
//   out_data [WIDTH]     - head entry, held in a register
module axil_buffer_fifo
  import axil_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axil_buffer_fifo: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop, full_d;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next pointers, flags and head register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    full_d      = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[IW-1:0] == rd_ptr_d[IW-1:0]);
    in_ready_d  = !full_d;
    out_valid_d = (wr_ptr_d != rd_ptr_d);
    // The slot being written can only be the next head when the FIFO is
    // (becoming) empty apart from this push; forward the input in that case.
    if (push && (wr_ptr_q[IW-1:0] == rd_ptr_d[IW-1:0])) begin
      out_data_d = in_data;
    end else begin
      out_data_d = mem_q[rd_ptr_d[IW-1:0]];
    end
  end

  // Pointer, flag and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
    out_data_q <= out_data_d;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[IW-1:0]] <= in_data;
    end
  end

endmodule

// File: rtl/axil_buffer.sv
// axil_buffer: AXI4-lite buffer with an independent FIFO on each channel.
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   s_axil_*   - slave port (connects to the upstream master)
//   m_axil_*   - master port (connects to the downstream slave)
// Optional macro AXIL_BUFFER_RESP_RESERVE_EN: limits outstanding writes/reads
// to the B/R buffering so that m_axil_bready/m_axil_rready never drop.
module axil_buffer
  import axil_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int AW_DEPTH   = 4,
  parameter int W_DEPTH    = 4,
  parameter int B_DEPTH    = 4,
  parameter int AR_DEPTH   = 4,
  parameter int R_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int AXW = ax_payload_w(ADDR_WIDTH);
  localparam int WW  = w_payload_w(DATA_WIDTH, STRB_WIDTH);
  localparam int RW  = r_payload_w(DATA_WIDTH);

  logic aw_in_valid, aw_fifo_ready, ar_in_valid, ar_fifo_ready;
  logic b_fifo_ready, r_fifo_ready;

`ifdef AXIL_BUFFER_RESP_RESERVE_EN
  localparam int WCW = ptr_width(B_DEPTH);
  localparam int RCW = ptr_width(R_DEPTH);

  logic [WCW-1:0] wr_out_q, wr_out_d;
  logic [RCW-1:0] rd_out_q, rd_out_d;
  logic           run_q, run_d;
  logic           wr_room, rd_room, aw_hs, b_hs, ar_hs, r_hs;

  assign wr_room = (wr_out_q < WCW'(B_DEPTH));
  assign rd_room = (rd_out_q < RCW'(R_DEPTH));
  assign aw_hs   = s_axil_awvalid & s_axil_awready;
  assign b_hs    = s_axil_bvalid & s_axil_bready;
  assign ar_hs   = s_axil_arvalid & s_axil_arready;
  assign r_hs    = s_axil_rvalid & s_axil_rready;

  // Outstanding-transaction counters; simultaneous inc and dec cancel.
  always_comb begin
    run_d = 1'b1;
    if (aw_hs && !b_hs) begin
      wr_out_d = wr_out_q + WCW'(1);
    end else if (!aw_hs && b_hs) begin
      wr_out_d = wr_out_q - WCW'(1);
    end else begin
      wr_out_d = wr_out_q;
    end
    if (ar_hs && !r_hs) begin
      rd_out_d = rd_out_q + RCW'(1);
    end else if (!ar_hs && r_hs) begin
      rd_out_d = rd_out_q - RCW'(1);
    end else begin
      rd_out_d = rd_out_q;
    end
  end

  // Counter and run-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_out_q <= '0;
      rd_out_q <= '0;
      run_q    <= 1'b0;
    end else begin
      wr_out_q <= wr_out_d;
      rd_out_q <= rd_out_d;
      run_q    <= run_d;
    end
  end

  assign s_axil_awready = aw_fifo_ready & wr_room;
  assign aw_in_valid    = s_axil_awvalid & wr_room;
  assign s_axil_arready = ar_fifo_ready & rd_room;
  assign ar_in_valid    = s_axil_arvalid & rd_room;
  // Room for every outstanding response is reserved, so the response FIFOs
  // can never be full when the slave answers; ready only drops in reset.
  assign m_axil_bready  = run_q;
  assign m_axil_rready  = run_q;
`else
  assign s_axil_awready = aw_fifo_ready;
  assign aw_in_valid    = s_axil_awvalid;
  assign s_axil_arready = ar_fifo_ready;
  assign ar_in_valid    = s_axil_arvalid;
  assign m_axil_bready  = b_fifo_ready;
  assign m_axil_rready  = r_fifo_ready;
`endif

  axil_buffer_fifo #(.WIDTH(AXW), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk), .rst(rst),
    .in_valid(aw_in_valid), .in_ready(aw_fifo_ready),
    .in_data({s_axil_awaddr, s_axil_awprot}),
    .out_valid(m_axil_awvalid), .out_ready(m_axil_awready),
    .out_data({m_axil_awaddr, m_axil_awprot})
  );

  axil_buffer_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk), .rst(rst),
    .in_valid(s_axil_wvalid), .in_ready(s_axil_wready),
    .in_data({s_axil_wdata, s_axil_wstrb}),
    .out_valid(m_axil_wvalid), .out_ready(m_axil_wready),
    .out_data({m_axil_wdata, m_axil_wstrb})
  );

  axil_buffer_fifo #(.WIDTH(B_PAYLOAD_W), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk(clk), .rst(rst),
    .in_valid(m_axil_bvalid), .in_ready(b_fifo_ready),
    .in_data(m_axil_bresp),
    .out_valid(s_axil_bvalid), .out_ready(s_axil_bready),
    .out_data(s_axil_bresp)
  );

  axil_buffer_fifo #(.WIDTH(AXW), .DEPTH(AR_DEPTH)) u_ar_fifo (
    .clk(clk), .rst(rst),
    .in_valid(ar_in_valid), .in_ready(ar_fifo_ready),
    .in_data({s_axil_araddr, s_axil_arprot}),
    .out_valid(m_axil_arvalid), .out_ready(m_axil_arready),
    .out_data({m_axil_araddr, m_axil_arprot})
  );

  axil_buffer_fifo #(.WIDTH(RW), .DEPTH(R_DEPTH)) u_r_fifo (
    .clk(clk), .rst(rst),
    .in_valid(m_axil_rvalid), .in_ready(r_fifo_ready),
    .in_data({m_axil_rdata, m_axil_rresp}),
    .out_valid(s_axil_rvalid), .out_ready(s_axil_rready),
    .out_data({s_axil_rdata, s_axil_rresp})
  );

endmodule
